// File: rtl/id_branch_unit_pkg.sv
// rtl/id_branch_unit_pkg.sv - shared types and opcodes for the ID-stage branch unit
// Purpose: branch_pkg holds the branch opcode enum, the zero-generator
//          comparator opcodes and the branch FSM state enum.
// Ports:   none (package).
package branch_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd2,
    BR_BGE  = 3'd3,
    BR_BLTU = 3'd4,
    BR_BGEU = 3'd5,
    BR_JAL  = 3'd6,
    BR_JALR = 3'd7
  } br_op_t;

  // Comparator opcodes understood by the ID zero generator.
  localparam logic [4:0] ZG_SUB  = 5'b00011;
  localparam logic [4:0] ZG_BLT  = 5'b00101;
  localparam logic [4:0] ZG_BGE  = 5'b01010;
  localparam logic [4:0] ZG_BLTU = 5'b00110;
  localparam logic [4:0] ZG_BGEU = 5'b01011;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_REDIRECT = 2'd2
  } br_state_t;

endpackage

// File: rtl/id_branch_unit_if.sv
// rtl/id_branch_unit_if.sv - ID-stage branch unit pipeline interface
// Purpose: bundles the decode-side inputs, the zero-generator handshake and
//          the PC redirect / flush outputs of the branch unit.
// Ports:   master = ID-stage / pipeline side, slave = id_branch_unit.
interface id_branch_unit_if
  import branch_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            br_valid;
  br_op_t          br_op;
  logic            opnd_ready;
  logic            hold;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data;
  logic [4:0]      alu_op;
  logic            zero;
  logic            id_stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            flush_if_id;
  logic            flush_id_ex;

  modport master (
    output br_valid, br_op, opnd_ready, hold, pc, imm, rs1_data, zero,
    input  alu_op, id_stall, redirect_valid, redirect_target,
    input  flush_if_id, flush_id_ex
  );

  modport slave (
    input  br_valid, br_op, opnd_ready, hold, pc, imm, rs1_data, zero,
    output alu_op, id_stall, redirect_valid, redirect_target,
    output flush_if_id, flush_id_ex
  );
endinterface

// File: rtl/id_branch_unit_counter.sv
// rtl/id_branch_unit_counter.sv - wrapping event counter for branch statistics
// Purpose: CNT_W-bit counter, increments when en is high, wraps all-ones to 0.
// Ports:   clk, rst (async, active high), en, count.
module branch_event_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/id_branch_unit.sv
// rtl/id_branch_unit.sv - ID-stage branch resolution, stall and PC redirect
// Purpose: picks the comparator opcode, decides taken/not-taken from zero,
//          stalls for unforwarded operands, issues a registered one-cycle
//          redirect with IF/ID and ID/EX flushes, and counts branch events.
// Ports:   clk, rst (async, active high), bus (id_branch_unit_if.slave),
//          br_cnt / taken_cnt (resolved and taken branch counts).
module id_branch_unit
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  id_branch_unit_if.slave    bus,
  output logic [CNT_W-1:0]   br_cnt,
  output logic [CNT_W-1:0]   taken_cnt
);

  br_state_t       state_q, state_d;
  logic [4:0]      alu_op;
  logic            taken;
  logic            resolve;
  logic            id_stall;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] target_q;

  always_comb begin
    alu_op = ZG_SUB;
    case (bus.br_op)
      BR_BLT:  alu_op = ZG_BLT;
      BR_BGE:  alu_op = ZG_BGE;
      BR_BLTU: alu_op = ZG_BLTU;
      BR_BGEU: alu_op = ZG_BGEU;
      default: alu_op = ZG_SUB;
    endcase
  end

  // Every conditional opcode except BNE is set up so that zero=1 means taken.
  always_comb begin
    taken = 1'b0;
    case (bus.br_op)
      BR_BNE:          taken = !bus.zero;
      BR_JAL, BR_JALR: taken = 1'b1;
      default:         taken = bus.zero;
    endcase
  end

  assign target = (bus.br_op == BR_JALR)
                ? ((bus.rs1_data + bus.imm) & ~XLEN'(1))
                : (bus.pc + bus.imm);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    id_stall = 1'b0;
    resolve  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.br_valid && !bus.hold) begin
          if (bus.opnd_ready) begin
            resolve = 1'b1;
          end else begin
            id_stall = 1'b1;
            state_d  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        id_stall = !bus.opnd_ready || bus.hold;
        if (bus.opnd_ready && !bus.hold) begin
          resolve = 1'b1;
          state_d = ST_IDLE;
        end
      end
      // The PC mux outranks the freeze, so hold is not looked at here, and
      // whatever sits in ID now is wrong-path and simply dropped.
      ST_REDIRECT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (resolve && taken) begin
      state_d = ST_REDIRECT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= '0;
    end else if (resolve && taken) begin
      target_q <= target;
    end
  end

  // Redirect and flushes come straight off the state register, so they are
  // registered and last exactly the one REDIRECT cycle.
  assign bus.alu_op          = alu_op;
  assign bus.id_stall        = id_stall;
  assign bus.redirect_valid  = (state_q == ST_REDIRECT);
  assign bus.flush_if_id     = (state_q == ST_REDIRECT);
  assign bus.flush_id_ex     = (state_q == ST_REDIRECT);
  assign bus.redirect_target = target_q;

  branch_event_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (resolve),
    .count (br_cnt)
  );

  branch_event_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (resolve && taken),
    .count (taken_cnt)
  );

endmodule

// File: tb/tb_id_branch_unit.sv
// tb/tb_id_branch_unit.sv - self-checking bench for id_branch_unit
// Purpose: directed branch scenarios; redirect targets go through a scoreboard
//          queue checked by an independent monitor.
// Ports:   none (top-level bench).
module tb_id_branch_unit;
  import branch_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;

  int n_total = 0;
  int n_pass  = 0;

  logic [XLEN-1:0] exp_q[$];

  id_branch_unit_if #(.XLEN(XLEN)) bus ();

  id_branch_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .br_cnt    (br_cnt),
    .taken_cnt (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Monitor: every redirect the DUT presents must match the oldest expected target.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.redirect_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_redirect", 32'(bus.redirect_target), 32'hFFFF_FFFF);
        end else begin
          chk("redirect_target", 32'(bus.redirect_target), 32'(exp_q.pop_front()));
          chk("flush_if_id", 32'(bus.flush_if_id), 32'd1);
          chk("flush_id_ex", 32'(bus.flush_id_ex), 32'd1);
        end
      end else if (bus.flush_if_id || bus.flush_id_ex) begin
        chk("stray_flush", 32'({bus.flush_if_id, bus.flush_id_ex}), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.br_valid = 1'b0; bus.br_op = BR_BEQ; bus.opnd_ready = 1'b0; bus.hold = 1'b0;
    bus.pc = '0; bus.imm = '0; bus.rs1_data = '0; bus.zero = 1'b0;
    step(); step();
    samp();
    chk("rst_stall", 32'(bus.id_stall), 0);
    chk("rst_redirect", 32'(bus.redirect_valid), 0);
    chk("rst_flush", 32'({bus.flush_if_id, bus.flush_id_ex}), 0);
    chk("rst_target", 32'(bus.redirect_target), 0);
    chk("rst_br_cnt", 32'(br_cnt), 0);
    chk("rst_taken_cnt", 32'(taken_cnt), 0);
    step();
    rst = 1'b0;

    // BEQ taken: 0x100 + 0x20
    bus.br_valid = 1'b1; bus.br_op = BR_BEQ; bus.pc = 32'h100; bus.imm = 32'h20;
    bus.zero = 1'b1; bus.opnd_ready = 1'b1;
    exp_q.push_back(32'h120);
    samp();
    chk("beq_alu_op", 32'(bus.alu_op), 32'h03);
    chk("beq_stall", 32'(bus.id_stall), 0);
    step();
    bus.br_valid = 1'b0;
    samp();
    chk("beq_br_cnt", 32'(br_cnt), 1);
    chk("beq_taken_cnt", 32'(taken_cnt), 1);
    step();

    // BNE with zero=1 is not taken
    bus.br_valid = 1'b1; bus.br_op = BR_BNE; bus.pc = 32'h140; bus.imm = 32'h8; bus.zero = 1'b1;
    samp();
    chk("bne_alu_op", 32'(bus.alu_op), 32'h03);
    step();
    bus.br_valid = 1'b0; bus.br_op = BR_BLTU;
    samp();
    chk("bne_br_cnt", 32'(br_cnt), 2);
    chk("bne_taken_cnt", 32'(taken_cnt), 1);
    chk("bne_redirect", 32'(bus.redirect_valid), 0);
    chk("bltu_alu_op", 32'(bus.alu_op), 32'h06);
    step();

    // BGE waiting 3 cycles for operands: 0x200 - 8
    bus.br_valid = 1'b1; bus.br_op = BR_BGE; bus.opnd_ready = 1'b0; bus.zero = 1'b1;
    bus.pc = 32'h200; bus.imm = 32'hFFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      samp();
      chk($sformatf("bge_stall_%0d", i), 32'(bus.id_stall), 1);
      step();
    end
    bus.opnd_ready = 1'b1;
    exp_q.push_back(32'h1F8);
    samp();
    chk("bge_stall_release", 32'(bus.id_stall), 0);
    chk("bge_alu_op", 32'(bus.alu_op), 32'h0A);
    step();
    bus.br_valid = 1'b0;
    samp();
    chk("bge_br_cnt", 32'(br_cnt), 3);
    chk("bge_taken_cnt", 32'(taken_cnt), 2);
    step();

    // JALR: (0x1003 + 4) & ~1, then a wrong-path branch during REDIRECT
    bus.br_valid = 1'b1; bus.br_op = BR_JALR; bus.pc = 32'h300; bus.rs1_data = 32'h1003;
    bus.imm = 32'h4; bus.opnd_ready = 1'b1; bus.zero = 1'b0;
    exp_q.push_back(32'h1006);
    samp();
    step();
    bus.br_op = BR_BEQ; bus.zero = 1'b1; bus.pc = 32'h500; bus.imm = 32'h40;
    samp();
    chk("wrongpath_stall", 32'(bus.id_stall), 0);
    chk("jalr_br_cnt", 32'(br_cnt), 4);
    step();
    bus.br_valid = 1'b0;
    samp();
    chk("wrongpath_br_cnt", 32'(br_cnt), 4);
    chk("wrongpath_taken_cnt", 32'(taken_cnt), 3);
    step();

    // BLT under hold for 2 cycles: 0x400 + 0x10
    bus.br_valid = 1'b1; bus.br_op = BR_BLT; bus.pc = 32'h400; bus.imm = 32'h10;
    bus.zero = 1'b1; bus.opnd_ready = 1'b1; bus.hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      samp();
      chk($sformatf("hold_stall_%0d", i), 32'(bus.id_stall), 0);
      chk($sformatf("hold_br_cnt_%0d", i), 32'(br_cnt), 4);
      step();
    end
    bus.hold = 1'b0;
    exp_q.push_back(32'h410);
    samp();
    chk("hold_frozen_br_cnt", 32'(br_cnt), 4);
    chk("blt_alu_op", 32'(bus.alu_op), 32'h05);
    step();
    bus.br_valid = 1'b0;
    samp();
    chk("hold_br_cnt", 32'(br_cnt), 5);
    chk("hold_taken_cnt", 32'(taken_cnt), 4);
    step();

    // Reset in WAIT
    bus.br_valid = 1'b1; bus.br_op = BR_BGEU; bus.opnd_ready = 1'b0;
    samp();
    chk("bgeu_stall", 32'(bus.id_stall), 1);
    chk("bgeu_alu_op", 32'(bus.alu_op), 32'h0B);
    step();
    samp();
    chk("wait_stall", 32'(bus.id_stall), 1);
    #1;
    rst = 1'b1; bus.br_valid = 1'b0;
    #1;
    chk("rstwait_stall", 32'(bus.id_stall), 0);
    chk("rstwait_br_cnt", 32'(br_cnt), 0);
    chk("rstwait_taken_cnt", 32'(taken_cnt), 0);
    chk("rstwait_redirect", 32'(bus.redirect_valid), 0);
    step();
    rst = 1'b0;

    // Reset in REDIRECT: the redirect is aborted
    bus.br_valid = 1'b1; bus.br_op = BR_BEQ; bus.zero = 1'b1; bus.opnd_ready = 1'b1;
    bus.pc = 32'h600; bus.imm = 32'h10;
    samp();
    step();
    bus.br_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstredir_redirect", 32'(bus.redirect_valid), 0);
    chk("rstredir_flush", 32'({bus.flush_if_id, bus.flush_id_ex}), 0);
    chk("rstredir_target", 32'(bus.redirect_target), 0);
    chk("rstredir_br_cnt", 32'(br_cnt), 0);
    chk("rstredir_taken_cnt", 32'(taken_cnt), 0);
    step();
    rst = 1'b0;

    // Counter wrap: 15 not-taken branches reach all-ones, the 16th wraps
    bus.br_valid = 1'b1; bus.br_op = BR_BNE; bus.zero = 1'b1; bus.opnd_ready = 1'b1;
    repeat (15) step();
    samp();
    chk("wrap_all_ones", 32'(br_cnt), 32'hF);
    step();
    bus.br_valid = 1'b0;
    samp();
    chk("wrap_zero", 32'(br_cnt), 0);
    chk("wrap_taken_cnt", 32'(taken_cnt), 0);
    step();
    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
